// File: rtl/regfile_pkg.sv
// Shared constants and bundle types for the register-file write side.
// Optional bypass build: define REGFILE_WB_FWD_EN.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on issue,
// cleared on accepted return; newer issue wins a same-cycle clash.
module regfile_scoreboard #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              busy_rs,
  output logic              busy_rt
);

  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_nxt;

  always_comb begin
    sb_nxt = sb;
    if (clr_en) sb_nxt[clr_idx] = 1'b0;
    if (set_en) sb_nxt[set_idx] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) sb <= '0;
    else          sb <= sb_nxt;
  end

  assign busy_rs = (rs != '0) & sb[rs];
  assign busy_rt = (rt != '0) & sb[rt];

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port: merges pipeline and load returns, tracks
// pending loads, drives decode stall/bypass. Macro: REGFILE_WB_FWD_EN.
module regfile_writeback #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pipe_valid,
  input  logic              pipe_regwrite,
  input  logic [ADDR_W-1:0] pipe_dest,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              ldu_issue,
  input  logic [ADDR_W-1:0] ldu_issue_dest,
  input  logic              ldu_valid,
  output logic              ldu_ready,
  input  logic [ADDR_W-1:0] ldu_dest,
  input  logic [DATA_W-1:0] ldu_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              stall,
  output logic              fwd_rs_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rt_data
);

  import regfile_pkg::*;

  wb_req_t pipe_req;
  wb_req_t ldu_req;
  wb_req_t win;
  logic    ldu_acc;
  logic    busy_rs;
  logic    busy_rt;
  logic    raw_rs;
  logic    raw_rt;

  always_comb begin
    pipe_req.valid = pipe_valid & pipe_regwrite
                   & (pipe_dest != REG_ZERO);
    pipe_req.dest  = pipe_dest;
    pipe_req.data  = pipe_data;
  end

  // pipeline always wins; loads only see backpressure
  assign ldu_ready = ~pipe_req.valid;
  assign ldu_acc   = ldu_valid & ldu_ready;

  always_comb begin
    ldu_req.valid = ldu_acc & (ldu_dest != REG_ZERO);
    ldu_req.dest  = ldu_dest;
    ldu_req.data  = ldu_data;
  end

  assign win = pipe_req.valid ? pipe_req : ldu_req;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= win.valid;
      if (win.valid) begin
        wr_addr <= win.dest;
        wr_data <= win.data;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_sb (
    .clock   (clock),
    .reset_n (reset_n),
    .set_en  (ldu_issue & (ldu_issue_dest != REG_ZERO)),
    .set_idx (ldu_issue_dest),
    .clr_en  (ldu_req.valid),
    .clr_idx (ldu_dest),
    .rs      (rs),
    .rt      (rt),
    .busy_rs (busy_rs),
    .busy_rt (busy_rt)
  );

  // register file reads and commits on the same edge
  assign raw_rs = wr_en & (wr_addr == rs) & (rs != REG_ZERO);
  assign raw_rt = wr_en & (wr_addr == rt) & (rt != REG_ZERO);

`ifdef REGFILE_WB_FWD_EN
  assign stall       = busy_rs | busy_rt;
  assign fwd_rs_hit  = raw_rs;
  assign fwd_rs_data = wr_data;
  assign fwd_rt_hit  = raw_rt;
  assign fwd_rt_data = wr_data;
`else
  assign stall       = busy_rs | busy_rt | raw_rs | raw_rt;
  assign fwd_rs_hit  = 1'b0;
  assign fwd_rs_data = '0;
  assign fwd_rt_hit  = 1'b0;
  assign fwd_rt_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed table plus random traffic
// checked against a set-of-pending-loads reference model.
module tb_regfile_writeback;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pipe_valid, pipe_regwrite;
  logic [4:0]  pipe_dest;
  logic [31:0] pipe_data;
  logic        ldu_issue;
  logic [4:0]  ldu_issue_dest;
  logic        ldu_valid, ldu_ready;
  logic [4:0]  ldu_dest;
  logic [31:0] ldu_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs, rt;
  logic        stall;
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;

  always #5 clock = ~clock;

  regfile_writeback dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pipe_valid     (pipe_valid),
    .pipe_regwrite  (pipe_regwrite),
    .pipe_dest      (pipe_dest),
    .pipe_data      (pipe_data),
    .ldu_issue      (ldu_issue),
    .ldu_issue_dest (ldu_issue_dest),
    .ldu_valid      (ldu_valid),
    .ldu_ready      (ldu_ready),
    .ldu_dest       (ldu_dest),
    .ldu_data       (ldu_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rs             (rs),
    .rt             (rt),
    .stall          (stall),
    .fwd_rs_hit     (fwd_rs_hit),
    .fwd_rs_data    (fwd_rs_data),
    .fwd_rt_hit     (fwd_rt_hit),
    .fwd_rt_data    (fwd_rt_data)
  );

  typedef struct {
    logic        rst_n, pv, prw;
    logic [4:0]  pd;
    logic [31:0] pdata;
    logic        iss;
    logic [4:0]  idst;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] ldata;
    logic [4:0]  rs, rt;
    logic        e_ready, e_s_on, e_s_off, e_hit, e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  int n_err = 0;
  int n_checks = 0;

  // reference model: last committed write and the set of pending loads
  bit        m_en;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        m_pend [32];

  function automatic vec_t mk(
    input bit rst_n, input bit pv, input bit prw,
    input logic [4:0] pd, input logic [31:0] pdata,
    input bit iss, input logic [4:0] idst,
    input bit lv, input logic [4:0] ld, input logic [31:0] ldata,
    input logic [4:0] rsv, input logic [4:0] rtv,
    input bit er, input bit son, input bit soff, input bit eh,
    input bit ew, input logic [4:0] ea, input logic [31:0] ed);
    vec_t v;
    v.rst_n = rst_n; v.pv = pv; v.prw = prw; v.pd = pd;
    v.pdata = pdata; v.iss = iss; v.idst = idst; v.lv = lv;
    v.ld = ld; v.ldata = ldata; v.rs = rsv; v.rt = rtv;
    v.e_ready = er; v.e_s_on = son; v.e_s_off = soff;
    v.e_hit = eh; v.e_wen = ew; v.e_wa = ea; v.e_wd = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && m_pend[r];
  endfunction

  function automatic bit commit_hit(input logic [4:0] r);
    return m_en && (m_addr == r) && (r != 0);
  endfunction

  task automatic check_comb();
    bit e_pwr, e_stall;
    e_pwr = pipe_valid && pipe_regwrite && (pipe_dest != 0);
    chk("ldu_ready", 32'(ldu_ready), 32'(!e_pwr));
`ifdef REGFILE_WB_FWD_EN
    e_stall = busy(rs) || busy(rt);
    chk("fwd_rs_hit", 32'(fwd_rs_hit), 32'(commit_hit(rs)));
    chk("fwd_rt_hit", 32'(fwd_rt_hit), 32'(commit_hit(rt)));
    chk("fwd_rs_data", fwd_rs_data, m_data);
    chk("fwd_rt_data", fwd_rt_data, m_data);
`else
    e_stall = busy(rs) || busy(rt) || commit_hit(rs) || commit_hit(rt);
    chk("fwd_rs_hit", 32'(fwd_rs_hit), 32'd0);
    chk("fwd_rt_hit", 32'(fwd_rt_hit), 32'd0);
    chk("fwd_rs_data", fwd_rs_data, 32'd0);
    chk("fwd_rt_data", fwd_rt_data, 32'd0);
`endif
    chk("stall", 32'(stall), 32'(e_stall));
  endtask

  task automatic model_edge();
    bit e_pwr, acc;
    if (!reset_n) begin
      m_en = 0; m_addr = 0; m_data = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      e_pwr = pipe_valid && pipe_regwrite && (pipe_dest != 0);
      acc = ldu_valid && !e_pwr;
      if (e_pwr) begin
        m_en = 1; m_addr = pipe_dest; m_data = pipe_data;
      end else if (acc && ldu_dest != 0) begin
        m_en = 1; m_addr = ldu_dest; m_data = ldu_data;
      end else begin
        m_en = 0;
      end
      if (acc) m_pend[ldu_dest] = 0;
      if (ldu_issue && ldu_issue_dest != 0) m_pend[ldu_issue_dest] = 1;
    end
  endtask

  task automatic step(input vec_t v, input bit tab);
    reset_n = v.rst_n; pipe_valid = v.pv; pipe_regwrite = v.prw;
    pipe_dest = v.pd; pipe_data = v.pdata;
    ldu_issue = v.iss; ldu_issue_dest = v.idst;
    ldu_valid = v.lv; ldu_dest = v.ld; ldu_data = v.ldata;
    rs = v.rs; rt = v.rt;
    #1;
    check_comb();
    if (tab) begin
      chk("tab_ready", 32'(ldu_ready), 32'(v.e_ready));
`ifdef REGFILE_WB_FWD_EN
      chk("tab_stall", 32'(stall), 32'(v.e_s_on));
      chk("tab_hit", 32'(fwd_rs_hit), 32'(v.e_hit));
`else
      chk("tab_stall", 32'(stall), 32'(v.e_s_off));
      chk("tab_hit", 32'(fwd_rs_hit), 32'd0);
`endif
    end
    @(posedge clock);
    model_edge();
    #1;
    chk("wr_en", 32'(wr_en), 32'(m_en));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", wr_data, m_data);
    if (tab) begin
      chk("tab_wr_en", 32'(wr_en), 32'(v.e_wen));
      chk("tab_wr_addr", 32'(wr_addr), 32'(v.e_wa));
      chk("tab_wr_data", wr_data, v.e_wd);
    end
  endtask

  vec_t tab [27];

  initial begin
    vec_t v;
    bit hold;
    logic [4:0] h_ld;
    logic [31:0] h_ldata;

    tab[0]  = mk(0,1,1,8,'h55,0,0,0,0,0,0,0,     0,0,0,0,0,0,0);
    tab[1]  = mk(0,1,1,8,'h55,0,0,0,0,0,0,0,     0,0,0,0,0,0,0);
    tab[2]  = mk(1,1,1,8,'h1234,0,0,0,0,0,0,0,   0,0,0,0,1,8,'h1234);
    tab[3]  = mk(1,0,0,0,0,0,0,0,0,0,8,0,        1,0,1,1,0,8,'h1234);
    tab[4]  = mk(1,1,1,9,'h9999,0,0,1,10,'hAAAA,0,0, 0,0,0,0,1,9,'h9999);
    tab[5]  = mk(1,0,0,0,0,0,0,1,10,'hAAAA,0,0,  1,0,0,0,1,10,'hAAAA);
    tab[6]  = mk(1,0,0,0,0,0,0,0,0,0,0,0,        1,0,0,0,0,10,'hAAAA);
    tab[7]  = mk(1,0,0,0,0,1,5,0,0,0,0,5,        1,0,0,0,0,10,'hAAAA);
    tab[8]  = mk(1,0,0,0,0,0,0,0,0,0,0,5,        1,1,1,0,0,10,'hAAAA);
    tab[9]  = mk(1,0,0,0,0,0,0,1,5,'h5555,0,5,   1,1,1,0,1,5,'h5555);
    tab[10] = mk(1,0,0,0,0,0,0,0,0,0,0,5,        1,0,1,0,0,5,'h5555);
    tab[11] = mk(1,0,0,0,0,1,5,0,0,0,0,5,        1,0,0,0,0,5,'h5555);
    tab[12] = mk(1,0,0,0,0,1,5,1,5,'h6666,0,5,   1,1,1,0,1,5,'h6666);
    tab[13] = mk(1,0,0,0,0,0,0,0,0,0,0,5,        1,1,1,0,0,5,'h6666);
    tab[14] = mk(1,0,0,0,0,0,0,1,5,'h7777,0,5,   1,1,1,0,1,5,'h7777);
    tab[15] = mk(1,0,0,0,0,0,0,0,0,0,0,0,        1,0,0,0,0,5,'h7777);
    tab[16] = mk(1,1,1,0,'hDEAD,0,0,0,0,0,0,0,   1,0,0,0,0,5,'h7777);
    tab[17] = mk(1,0,0,0,0,1,0,1,0,'hBEEF,0,0,   1,0,0,0,0,5,'h7777);
    tab[18] = mk(1,0,0,0,0,0,0,0,0,0,0,0,        1,0,0,0,0,5,'h7777);
    tab[19] = mk(1,1,1,7,'h77,0,0,0,0,0,0,0,     0,0,0,0,1,7,'h77);
    tab[20] = mk(1,0,0,0,0,0,0,0,0,0,7,0,        1,0,1,1,0,7,'h77);
    tab[21] = mk(1,0,0,0,0,0,0,0,0,0,7,0,        1,0,0,0,0,7,'h77);
    tab[22] = mk(1,0,0,0,0,1,12,0,0,0,12,0,      1,0,0,0,0,7,'h77);
    tab[23] = mk(0,0,0,0,0,0,0,0,0,0,12,0,       1,1,1,0,0,0,0);
    tab[24] = mk(1,0,0,0,0,0,0,1,12,'hC0C0,12,0, 1,0,0,0,1,12,'hC0C0);
    tab[25] = mk(1,0,0,0,0,0,0,0,0,0,12,0,       1,0,1,1,0,12,'hC0C0);
    tab[26] = mk(1,1,0,3,1,0,0,1,4,'h44,0,0,     1,0,0,0,1,4,'h44);

    reset_n = 0; pipe_valid = 0; pipe_regwrite = 0; pipe_dest = 0;
    pipe_data = 0; ldu_issue = 0; ldu_issue_dest = 0; ldu_valid = 0;
    ldu_dest = 0; ldu_data = 0; rs = 0; rt = 0;
    @(posedge clock);
    #1;
    model_edge();

    for (int i = 0; i < 27; i++) step(tab[i], 1'b1);

    hold = 0; h_ld = 0; h_ldata = 0;
    for (int i = 0; i < 800; i++) begin
      v = tab[0];
      v.rst_n = ($urandom_range(0, 63) != 0);
      v.pv    = 1'($urandom_range(0, 1));
      v.prw   = ($urandom_range(0, 3) != 0);
      v.pd    = 5'($urandom_range(0, 7));
      v.pdata = $urandom;
      v.iss   = 1'($urandom_range(0, 1));
      v.idst  = 5'($urandom_range(0, 7));
      if (hold) begin
        v.lv = 1; v.ld = h_ld; v.ldata = h_ldata;
      end else begin
        v.lv    = 1'($urandom_range(0, 1));
        v.ld    = 5'($urandom_range(0, 7));
        v.ldata = $urandom;
      end
      v.rs = 5'($urandom_range(0, 7));
      v.rt = 5'($urandom_range(0, 7));
      hold = v.lv && v.pv && v.prw && (v.pd != 0);
      h_ld = v.ld; h_ldata = v.ldata;
      step(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
